// File: rtl/axi_stream_traffic_checker_v1_0_s00_axis_if.sv
// AXI-Stream bundle between the switch output port and the traffic checker.
interface axi_stream_traffic_checker_v1_0_s00_axis_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic                  TVALID;
    logic                  TREADY;
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TLAST;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/axi_stream_traffic_checker_v1_0_s00_axis.sv
// AXI-Stream sink that checks traffic-generator packets (header/body/tail/length)
// and keeps per-VC good counters, a bad-packet counter and sticky error flags.
module axi_stream_traffic_checker_v1_0_s00_axis #(
    parameter int C_S_AXIS_TDATA_WIDTH = 128,
    parameter int PKT_WORDS            = 18,
    parameter int prio_num             = 2,
    parameter int vc_num               = 2,
    parameter int CNT_WIDTH            = 16,
    localparam int NVC                 = prio_num * vc_num,
    localparam int VC_W                = (NVC > 1) ? $clog2(NVC) : 1
) (
    input  logic                                      S_AXIS_ACLK,
    input  logic                                      S_AXIS_ARESET,
    input  logic                                      enable,
    input  logic                                      i_backpressure,
    axi_stream_traffic_checker_v1_0_s00_axis_if.slave S_AXIS,
    output logic                                      o_pkt_done,
    output logic                                      o_pkt_ok,
    output logic [VC_W-1:0]                           o_pkt_vc,
    output logic [NVC*CNT_WIDTH-1:0]                  o_good_cnt,
    output logic [CNT_WIDTH-1:0]                      o_err_cnt,
    output logic [3:0]                                o_err_flags
);

    localparam int BW = $clog2(PKT_WORDS + 1);

    localparam logic [3:0] F_HDR  = 4'b0001;
    localparam logic [3:0] F_BODY = 4'b0010;
    localparam logic [3:0] F_TAIL = 4'b0100;
    localparam logic [3:0] F_LEN  = 4'b1000;

    typedef enum logic [1:0] {
        HDR,
        BODY,
        DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [3:0]               pend_flags_q, pend_flags_d;
    logic [VC_W-1:0]          cap_vc_q, cap_vc_d;

    logic                     done_q, done_d;
    logic                     ok_q, ok_d;
    logic [VC_W-1:0]          vc_q, vc_d;
    logic [NVC*CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_WIDTH-1:0]     err_cnt_q, err_cnt_d;
    logic [3:0]               flags_q, flags_d;

    logic [C_S_AXIS_TDATA_WIDTH-1:0] tdata;
    logic                     tlast;
    logic                     tready;
    logic                     accept;
    logic                     hdr_ok, body_ok, tail_ok;
    logic                     complete;
    logic [3:0]               comp_flags;
    logic [VC_W-1:0]          comp_vc;

    assign tdata         = S_AXIS.TDATA;
    assign tlast         = S_AXIS.TLAST;
    assign tready        = ~S_AXIS_ARESET & enable & ~i_backpressure;
    assign S_AXIS.TREADY = tready;
    assign accept        = S_AXIS.TVALID & tready;

    assign hdr_ok  = (tdata[127:96] == 32'hAAAAAAAA) &&
                     (tdata[95:64]  == 32'h0) &&
                     (tdata[31:5]   == 27'h0AAAAAA) &&
                     (32'(tdata[4:0]) < NVC);
    assign body_ok = (tdata[127:96] == 32'hDEADBEEF) &&
                     (tdata[31:0]   == 32'hDEADBEEF) &&
                     (tdata[95:64]  == tdata[63:32]);
    assign tail_ok = (tdata == '0);

    // Packet walker: a failure before TLAST parks in DRAIN with the fault
    // remembered, so the packet is reported once, on its own TLAST beat.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        pend_flags_d = pend_flags_q;
        cap_vc_d     = cap_vc_q;
        complete     = 1'b0;
        comp_flags   = pend_flags_q;
        comp_vc      = cap_vc_q;
        if (accept) begin
            unique case (state_q)
                HDR: begin
                    beat_cnt_d   = BW'(1);
                    cap_vc_d     = tdata[VC_W-1:0];
                    comp_vc      = tdata[VC_W-1:0];
                    pend_flags_d = hdr_ok ? 4'b0000 : F_HDR;
                    if (tlast) begin
                        complete     = 1'b1;
                        comp_flags   = (hdr_ok ? 4'b0000 : F_HDR) | F_LEN;
                        pend_flags_d = 4'b0000;
                        state_d      = HDR;
                    end else if (!hdr_ok) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = BODY;
                    end
                end
                BODY: begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_cnt_q < BW'(PKT_WORDS - 1)) begin
                        if (tlast) begin
                            complete   = 1'b1;
                            comp_flags = (body_ok ? 4'b0000 : F_BODY) | F_LEN;
                            state_d    = HDR;
                        end else if (!body_ok) begin
                            pend_flags_d = F_BODY;
                            state_d      = DRAIN;
                        end
                    end else begin
                        if (!tlast) begin
                            pend_flags_d = (tail_ok ? 4'b0000 : F_TAIL) | F_LEN;
                            state_d      = DRAIN;
                        end else begin
                            complete   = 1'b1;
                            comp_flags = tail_ok ? 4'b0000 : F_TAIL;
                            state_d    = HDR;
                        end
                    end
                end
                DRAIN: begin
                    if (tlast) begin
                        complete = 1'b1;
                        state_d  = HDR;
                    end
                end
                default: state_d = HDR;
            endcase
        end
    end

    // Completion report and statistics, registered one cycle after the last beat.
    always_comb begin
        done_d     = complete;
        ok_d       = complete && (comp_flags == 4'b0000);
        vc_d       = complete ? comp_vc : vc_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        flags_d    = flags_q;
        if (complete) begin
            flags_d = flags_q | comp_flags;
            if (comp_flags == 4'b0000) begin
                for (int k = 0; k < NVC; k++) begin
                    if (comp_vc == VC_W'(k)) begin
                        good_cnt_d[k*CNT_WIDTH +: CNT_WIDTH] =
                            good_cnt_q[k*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                    end
                end
            end else begin
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state_q      <= HDR;
            beat_cnt_q   <= '0;
            pend_flags_q <= '0;
            cap_vc_q     <= '0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            vc_q         <= '0;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            pend_flags_q <= pend_flags_d;
            cap_vc_q     <= cap_vc_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            vc_q         <= vc_d;
            good_cnt_q   <= good_cnt_d;
            err_cnt_q    <= err_cnt_d;
            flags_q      <= flags_d;
        end
    end

    assign o_pkt_done  = done_q;
    assign o_pkt_ok    = ok_q;
    assign o_pkt_vc    = vc_q;
    assign o_good_cnt  = good_cnt_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_err_flags = flags_q;

endmodule

// File: tb/tb_axi_stream_traffic_checker_v1_0_s00_axis.sv
// Self-checking bench for the AXI-Stream traffic checker: directed packet
// scenarios plus randomized traffic, compared against a packet-level model.
module tb_axi_stream_traffic_checker_v1_0_s00_axis;

   localparam int P   = 18;
   localparam int NVC = 4;

   localparam logic [3:0] FH = 4'b0001;
   localparam logic [3:0] FB = 4'b0010;
   localparam logic [3:0] FT = 4'b0100;
   localparam logic [3:0] FL = 4'b1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        bp;
   logic        pktDone;
   logic        pktOk;
   logic [1:0]  pktVc;
   logic [63:0] goodCnt;
   logic [15:0] errCnt;
   logic [3:0]  errFlags;

   axi_stream_traffic_checker_v1_0_s00_axis_if #(.DATA_WIDTH(128)) sAxis ();

   axi_stream_traffic_checker_v1_0_s00_axis dut (
      .S_AXIS_ACLK    (clk),
      .S_AXIS_ARESET  (rst),
      .enable         (enable),
      .i_backpressure (bp),
      .S_AXIS         (sAxis),
      .o_pkt_done     (pktDone),
      .o_pkt_ok       (pktOk),
      .o_pkt_vc       (pktVc),
      .o_good_cnt     (goodCnt),
      .o_err_cnt      (errCnt),
      .o_err_flags    (errFlags)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // One queued beat; the packet outcome rides on its TLAST beat
   typedef struct {
      logic [127:0] data;
      logic         last;
      logic         ok;
      logic [1:0]   vc;
      logic [3:0]   flags;
   } beat_t;

   beat_t       beatQ[$];
   logic [15:0] modelGood [4];
   logic [15:0] modelErr;
   logic [3:0]  modelFlags;
   logic        expDone;
   logic        expOk;
   logic [1:0]  expVc;
   int          checkCount = 0;
   int          failCount  = 0;
   int          doneSeen   = 0;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [127:0] flipBit(input logic [127:0] d, input int b);
      d[b] = ~d[b];
      return d;
   endfunction

   // Builds one packet from a description of its faults and predicts its
   // outcome straight from the packet rules: first fault wins, a missing
   // or premature TLAST is a length error, and header faults hide the rest.
   task automatic addPacket(input int vc5, input bit hdrBad, input int bodyBad,
                            input bit tailBad, input int lastPos);
      beat_t        b;
      logic [127:0] d;
      logic [31:0]  r;
      logic [3:0]   f;
      bit           hdrOk;
      int           pick;
      hdrOk = !hdrBad && (vc5 < NVC);
      if (lastPos == 0)
         f = FL | (hdrOk ? 4'b0000 : FH);
      else if (!hdrOk)
         f = FH;
      else if (bodyBad >= 1 && bodyBad <= P-2 && bodyBad <= lastPos)
         f = FB | ((bodyBad == lastPos) ? FL : 4'b0000);
      else if (lastPos < P-1)
         f = FL;
      else
         f = (tailBad ? FT : 4'b0000) | ((lastPos > P-1) ? FL : 4'b0000);
      for (int i = 0; i <= lastPos; i++) begin
         if (i == 0) begin
            d = {32'hAAAAAAAA, 32'h0, $urandom(), 27'h0AAAAAA, 5'(vc5)};
            if (hdrBad) begin
               pick = $urandom_range(0, 90);
               d = flipBit(d, (pick < 64) ? (64 + pick) : (pick - 59));
            end
         end else if (i <= P-2) begin
            r = $urandom();
            d = {32'hDEADBEEF, r, r, 32'hDEADBEEF};
            if (i == bodyBad) d = flipBit(d, $urandom_range(0, 127));
         end else if (i == P-1) begin
            d = '0;
            if (tailBad) d = flipBit(d, $urandom_range(0, 127));
         end else begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
         end
         b.data  = d;
         b.last  = (i == lastPos);
         b.ok    = (f == 4'b0000);
         b.vc    = 2'(vc5);
         b.flags = f;
         beatQ.push_back(b);
      end
   endtask

   // Drives one cycle of inputs: enable/backpressure pattern and the next beat
   task automatic applyStimulus(input int validPct, input int bpMode, input int enPct);
      enable = ($urandom_range(0, 99) < enPct);
      case (bpMode)
         0:       bp = 1'b0;
         1:       bp = ~bp;
         default: bp = ($urandom_range(0, 3) == 0);
      endcase
      if (beatQ.size() > 0 && $urandom_range(0, 99) < validPct) begin
         sAxis.TVALID = 1'b1;
         sAxis.TDATA  = beatQ[0].data;
         sAxis.TLAST  = beatQ[0].last;
      end else begin
         sAxis.TVALID = 1'b0;
         sAxis.TDATA  = {$urandom(), $urandom(), $urandom(), $urandom()};
         sAxis.TLAST  = 1'($urandom_range(0, 1));
      end
   endtask

   // Advances one clock: predicts acceptance from the bench's own inputs,
   // updates the model on the edge, then checks every output 1 ns later.
   task automatic runCycle();
      logic  expReady;
      logic  accept;
      beat_t b;
      expReady = enable & ~bp;
      accept   = sAxis.TVALID & expReady;
      #1;
      checkOutput("tready", sAxis.TREADY, expReady);
      @(posedge clk);
      expDone = 1'b0;
      if (accept) begin
         b = beatQ.pop_front();
         if (b.last) begin
            expDone = 1'b1;
            expOk   = b.ok;
            expVc   = b.vc;
            if (b.ok) modelGood[b.vc] = modelGood[b.vc] + 16'd1;
            else      modelErr = modelErr + 16'd1;
            modelFlags = modelFlags | b.flags;
         end
      end
      #1;
      checkOutput("done", pktDone, expDone);
      if (pktDone) doneSeen++;
      if (expDone) begin
         checkOutput("ok", pktOk, expOk);
         checkOutput("vc", pktVc, expVc);
      end
      for (int k = 0; k < NVC; k++)
         checkOutput($sformatf("goodCnt%0d", k), goodCnt[k*16 +: 16], modelGood[k]);
      checkOutput("errCnt", errCnt, modelErr);
      checkOutput("errFlags", errFlags, modelFlags);
   endtask

   // Streams every queued beat, then idles two cycles to catch the last pulse
   task automatic runTraffic(input int validPct, input int bpMode, input int enPct);
      int budget = 20000;
      while (beatQ.size() > 0 && budget > 0) begin
         applyStimulus(validPct, bpMode, enPct);
         runCycle();
         budget--;
      end
      checkOutput("drainBudget", beatQ.size(), 0);
      repeat (2) begin
         applyStimulus(0, 0, 100);
         runCycle();
      end
   endtask

   // Asserts reset between edges, confirms the asynchronous clear, clears the model
   task automatic applyReset();
      rst          = 1'b1;
      enable       = 1'b1;
      bp           = 1'b0;
      sAxis.TVALID = 1'b1;
      #2;
      checkOutput("rstTready", sAxis.TREADY, 0);
      checkOutput("rstDone", pktDone, 0);
      checkOutput("rstOk", pktOk, 0);
      checkOutput("rstVc", pktVc, 0);
      checkOutput("rstGood", goodCnt, 0);
      checkOutput("rstErr", errCnt, 0);
      checkOutput("rstFlags", errFlags, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      beatQ.delete();
      for (int k = 0; k < NVC; k++) modelGood[k] = '0;
      modelErr   = '0;
      modelFlags = '0;
      expDone    = 1'b0;
      doneSeen   = 0;
   endtask

   // Main sequence: directed scenarios first, then randomized packet mixes
   initial begin
      int kind;
      rst          = 1'b1;
      enable       = 1'b0;
      bp           = 1'b0;
      sAxis.TVALID = 1'b0;
      sAxis.TDATA  = '0;
      sAxis.TLAST  = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] three good packets to VC 2, no backpressure");
      applyReset();
      repeat (3) addPacket(2, 0, 0, 0, P-1);
      runTraffic(100, 0, 100);
      checkOutput("s1Dones", doneSeen, 3);
      checkOutput("s1Good2", goodCnt[47:32], 3);
      checkOutput("s1Err", errCnt, 0);
      checkOutput("s1Flags", errFlags, 0);

      $display("[TB] same traffic with 50%% backpressure");
      applyReset();
      repeat (3) addPacket(2, 0, 0, 0, P-1);
      runTraffic(100, 1, 100);
      checkOutput("s2Dones", doneSeen, 3);
      checkOutput("s2Good2", goodCnt[47:32], 3);
      checkOutput("s2Err", errCnt, 0);

      $display("[TB] header VC out of range, then good packet to VC 1");
      applyReset();
      addPacket(7, 0, 0, 0, P-1);
      addPacket(1, 0, 0, 0, P-1);
      runTraffic(100, 0, 100);
      checkOutput("s3Err", errCnt, 1);
      checkOutput("s3Flags", errFlags, 4'b0001);
      checkOutput("s3Good1", goodCnt[31:16], 1);

      $display("[TB] body beat 5 with mismatched halves");
      applyReset();
      addPacket(2, 0, 5, 0, P-1);
      beatQ[5].data = {32'hDEADBEEF, 32'd1, 32'd2, 32'hDEADBEEF};
      runTraffic(100, 0, 100);
      checkOutput("s4Err", errCnt, 1);
      checkOutput("s4Flags", errFlags, 4'b0010);

      $display("[TB] early TLAST on beat 10, then good packet");
      applyReset();
      addPacket(0, 0, 0, 0, 9);
      addPacket(0, 0, 0, 0, P-1);
      runTraffic(100, 0, 100);
      checkOutput("s5Err", errCnt, 1);
      checkOutput("s5Flags", errFlags, 4'b1000);
      checkOutput("s5Good0", goodCnt[15:0], 1);

      $display("[TB] missing TLAST on beat 18, TLAST on beat 20, then mid-packet reset");
      applyReset();
      addPacket(1, 0, 0, 0, 19);
      runTraffic(100, 0, 100);
      checkOutput("s6Err", errCnt, 1);
      checkOutput("s6Flags", errFlags, 4'b1000);
      addPacket(0, 0, 0, 0, P-1);
      repeat (8) begin
         applyStimulus(100, 0, 100);
         runCycle();
      end
      applyReset();
      addPacket(3, 0, 0, 0, P-1);
      runTraffic(100, 0, 100);
      checkOutput("s6Good3", goodCnt[63:48], 1);
      checkOutput("s6Good0", goodCnt[15:0], 0);
      checkOutput("s6ErrAfter", errCnt, 0);

      $display("[TB] randomized packet mix");
      applyReset();
      for (int batch = 0; batch < 4; batch++) begin
         for (int n = 0; n < 12; n++) begin
            kind = $urandom_range(0, 9);
            case (kind)
               6: begin
                  if ($urandom_range(0, 1) == 1)
                     addPacket($urandom_range(4, 31), 0, 0, 0, P-1);
                  else
                     addPacket($urandom_range(0, 3), 1, 0, 0, $urandom_range(0, P+1));
               end
               7: addPacket($urandom_range(0, 3), 0, $urandom_range(1, P-2), 0, P-1);
               8: addPacket($urandom_range(0, 3), 0, 0, 0, $urandom_range(0, P-2));
               9: addPacket($urandom_range(0, 3), 0, 0, 1'($urandom_range(0, 1)),
                            $urandom_range(P-1, P+3));
               default: addPacket($urandom_range(0, 3), 0, 0, 0, P-1);
            endcase
         end
         case (batch)
            0:       runTraffic(100, 0, 100);
            1:       runTraffic(70, 2, 90);
            2:       runTraffic(50, 1, 80);
            default: runTraffic(90, 2, 100);
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/axi_stream_traffic_checker_v1_0_s00_axis.md
Name: axi_stream_traffic_checker_v1_0_S00_AXIS

Overview:
- AXI-Stream sink and checker for the traffic generator's packet stream.
- Sits at a switch output port in the s2e testbench.
- Accepts packets under programmable backpressure, checks header, body and tail format, and detects length errors.
- Keeps per-VC good-packet counters plus error counters and flags for the testbench to inspect.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 128, stream data width; fixed at 128 by the packet format.
- PKT_WORDS, 18, beats per packet: 1 header, PKT_WORDS-2 body, 1 tail. Minimum 3.
- prio_num, 2, number of priorities.
- vc_num, 2, VCs per priority. NVC = prio_num*vc_num.
- CNT_WIDTH, 16, width of each counter.

Ports:
- S_AXIS_ACLK  in  1  clock.
- S_AXIS_ARESET  in  1  reset, asynchronous, active-high.
- enable  in  1  checker enable; when low, TREADY is 0.
- i_backpressure  in  1  when high, TREADY is forced to 0 this cycle.
- S_AXIS  AXIS.slave  interface  uses TVALID, TREADY, TDATA[127:0] and TLAST.
- o_pkt_done  out  1  one-cycle pulse when a packet completes (good or bad).
- o_pkt_ok  out  1  valid with o_pkt_done; 1 means the packet passed every check.
- o_pkt_vc  out  $clog2(NVC)  header VC field of the completed packet, valid with o_pkt_done.
- o_good_cnt  out  NVC*CNT_WIDTH  per-VC good-packet counters; VC k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
- o_err_cnt  out  CNT_WIDTH  number of bad packets.
- o_err_flags  out  4  sticky flags: [0] header, [1] body, [2] tail, [3] length.

Behaviour:
- Reset is asynchronous. While S_AXIS_ARESET is high:
  - all outputs and counters are 0; TREADY is 0;
  - the FSM is in HDR and the beat counter is 0.
  - Reset asserted mid-packet discards that packet without counting it.
- TREADY = enable & ~i_backpressure, combinational, outside reset. A beat is accepted when TVALID & TREADY. Nothing advances on unaccepted cycles.
- Header check, all conditions required:
  - TDATA[127:96] == 32'hAAAAAAAA;
  - TDATA[95:64] == 0;
  - TDATA[31:5] == 27'h0AAAAAA;
  - TDATA[4:0] < NVC.
  - Bits [63:32] are random and not checked. o_pkt_vc is captured from TDATA[4:0], truncated to $clog2(NVC) bits.
- Body check, all conditions required:
  - TDATA[127:96] == 32'hDEADBEEF;
  - TDATA[31:0] == 32'hDEADBEEF;
  - TDATA[95:64] == TDATA[63:32].
- Tail check: TDATA == 0.
- FSM states:
  - HDR: on an accepted beat, run the header check and set beat_cnt = 1.
    - TLAST=1: length error, finish the packet as bad, stay in HDR.
    - Header fails: finish bad later; go to DRAIN.
    - Otherwise go to BODY.
  - BODY: each accepted beat increments beat_cnt.
    - If beat_cnt < PKT_WORDS-1, this is a body beat. Run the body check. TLAST=1 here is an early end: length error, packet bad, go to HDR. A body failure goes to DRAIN.
    - If beat_cnt == PKT_WORDS-1, this is the tail beat. Run the tail check. If TLAST=0, raise a length error and go to DRAIN; otherwise go to HDR.
  - DRAIN: discard accepted beats until an accepted beat has TLAST=1, then go to HDR.
    - Packet completion is signalled on the TLAST beat, not on entry to DRAIN.
    - The length flag is raised only for the missing-TLAST case.
- Completion, registered: the cycle after the completing beat, o_pkt_done=1 for exactly one cycle.
  - Good packet: o_pkt_ok=1 and o_good_cnt[vc] increments.
  - Bad packet: o_pkt_ok=0 and o_err_cnt increments. Each failing check ORs its bit into o_err_flags.
  - A bad packet counts exactly once, even with multiple faults.
- Counters wrap modulo 2^CNT_WIDTH. Error flags clear only on reset.
- Back-to-back packets with zero idle cycles are supported. A header beat may be accepted in the cycle after the tail beat, while o_pkt_done is high.
- enable going low mid-packet only stalls the checker; state is held.

Test Plan:
- Reset, then 3 good packets to VC 2 with TVALID held high and no backpressure.
  -> 3 o_pkt_done pulses, each with o_pkt_ok=1 and o_pkt_vc=2.
  -> good_cnt[2]=3, err_cnt=0, flags=0. Done pulses fall on cycles 19, 37 and 55 after the first accepted beat.
- Same traffic with i_backpressure toggled every other cycle (50%).
  -> identical counters; no beat is lost or duplicated.
  -> TREADY is 0 in exactly the backpressure cycles.
- Packet whose header has TDATA[4:0]=7 (with NVC=4), followed by a good packet to VC 1.
  -> first packet: err_cnt=1, flags=4'b0001, done signalled on its TLAST beat.
  -> second packet: good_cnt[1]=1.
- Body beat 5 with TDATA[95:64]=1 and TDATA[63:32]=2.
  -> flags=4'b0010, err_cnt=1; the remaining beats are drained.
- TLAST on beat 10, then a good packet.
  -> flags=4'b1000, err_cnt=1, and the next packet is good with no resync loss.
- Missing TLAST on beat 18, with TLAST arriving on beat 20.
  -> flags=4'b1000, one error counted. Reset asserted mid-packet clears everything, and the next packet is checked cleanly.
